// File: rtl/shift_bank_display_if.sv
// Board-side switch/LED/seven-segment bundle for shift_bank_display.
// The master drives the slide switches; the slave owns the LEDs and the digits.
interface shift_bank_display_if;
    // SW[WIDTH-1:0] = data, SW[9:8] = mode
    logic [9:0] SW;
    // [5:0] valid mask, [8] sticky overflow, [9] full
    logic [9:0] LEDR;
    // active-low {g,f,e,d,c,b,a}
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output SW,
        input  LEDR,
        input  HEX0,
        input  HEX1,
        input  HEX2,
        input  HEX3,
        input  HEX4,
        input  HEX5
    );

    modport slave (
        input  SW,
        output LEDR,
        output HEX0,
        output HEX1,
        output HEX2,
        output HEX3,
        output HEX4,
        output HEX5
    );
endinterface

// File: rtl/shift_bank_display.sv
// DEPTH-stage, WIDTH-bit shift register bank clocked by a pushbutton.
// Modes: hold, shift-in, rotate (only when full), synchronous clear.
// Each stage drives one seven-segment digit; LEDs show fill mask, full and
// sticky overflow. All outputs are combinational from the registered state.
module shift_bank_display #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 6
) (
    input logic [1:0]           KEY,
    shift_bank_display_if.slave bus
);

    // Static parameter range checks; no hardware is generated by these.
    if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
        $error("shift_bank_display: WIDTH must be in 1..4");
    end
    if (DEPTH < 1 || DEPTH > 6) begin : g_bad_depth
        $error("shift_bank_display: DEPTH must be in 1..6");
    end

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeShift  = 2'b01,
        ModeRotate = 2'b10,
        ModeClear  = 2'b11
    } mode_e;

    localparam logic [6:0] Dash  = 7'b0111111;
    localparam logic [6:0] Blank = 7'b1111111;
    localparam logic [2:0] CntFull = 3'(DEPTH);

    logic             clk;
    logic             rst_n;
    mode_e            mode;
    logic [WIDTH-1:0] din;

    assign clk   = KEY[0];
    assign rst_n = KEY[1];
    assign mode  = mode_e'(bus.SW[9:8]);
    assign din   = bus.SW[WIDTH-1:0];

    // Switches between the data field and the mode field carry no function.
    logic unused_sw;
    assign unused_sw = ^bus.SW[7:WIDTH];

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [2:0]       cnt_q;
    logic             ovf_q;
    logic             full;

    assign full = (cnt_q == CntFull);

    // Active-low hex glyph for one nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] seg;
        unique case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = Blank;
        endcase
        return seg;
    endfunction

    // Stage bank, fill counter and sticky overflow; reset wins over a coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
            cnt_q <= 3'd0;
            ovf_q <= 1'b0;
        end else begin
            unique case (mode)
                ModeHold: begin
                end
                ModeShift: begin
                    stage_q[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                    if (!full) begin
                        cnt_q <= cnt_q + 3'd1;
                    end else begin
                        // Oldest stage falls off the end.
                        ovf_q <= 1'b1;
                    end
                end
                ModeRotate: begin
                    // A partially filled bank would rotate dashes into view, so hold instead.
                    if (full) begin
                        stage_q[0] <= stage_q[DEPTH-1];
                        for (int i = 1; i < int'(DEPTH); i++) begin
                            stage_q[i] <= stage_q[i-1];
                        end
                    end
                end
                ModeClear: begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_q[i] <= '0;
                    end
                    cnt_q <= 3'd0;
                    ovf_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    logic [5:0] valid_mask;

    // Thermometer valid mask: stage i is loaded when i < cnt.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < 6; i++) begin
            valid_mask[i] = (i < int'(DEPTH)) && (3'(i) < cnt_q);
        end
    end

    assign bus.LEDR = {full, ovf_q, 2'b00, valid_mask};

    logic [5:0][6:0] hex_seg;

    for (genvar g = 0; g < 6; g++) begin : g_digit
        if (g < DEPTH) begin : g_used
            assign hex_seg[g] = (3'(g) < cnt_q) ? hex_glyph(4'(stage_q[g])) : Dash;
        end else begin : g_blank
            assign hex_seg[g] = Blank;
        end
    end

    assign bus.HEX0 = hex_seg[0];
    assign bus.HEX1 = hex_seg[1];
    assign bus.HEX2 = hex_seg[2];
    assign bus.HEX3 = hex_seg[3];
    assign bus.HEX4 = hex_seg[4];
    assign bus.HEX5 = hex_seg[5];

endmodule

// File: tb/tb_shift_bank_display.sv
// Directed bench for shift_bank_display: default 4x6 bank plus a 1x2 bank.
module tb_shift_bank_display;

    localparam logic [6:0] D  = 7'b0111111;  // dash
    localparam logic [6:0] BL = 7'b1111111;  // blank
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110;

    logic [1:0] key_a;
    logic [1:0] key_b;
    int n_checks;
    int n_fail;

    shift_bank_display_if bus_a ();
    shift_bank_display_if bus_b ();

    shift_bank_display #(.WIDTH(4), .DEPTH(6)) u_dut_a (
        .KEY (key_a),
        .bus (bus_a.slave)
    );

    shift_bank_display #(.WIDTH(1), .DEPTH(2)) u_dut_b (
        .KEY (key_b),
        .bus (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [9:0] ledr,
                           input logic [6:0] h0, input logic [6:0] h1, input logic [6:0] h2,
                           input logic [6:0] h3, input logic [6:0] h4, input logic [6:0] h5);
        check_eq({tag, ".ledr"}, 32'(bus_a.LEDR), 32'(ledr));
        check_eq({tag, ".hex0"}, 32'(bus_a.HEX0), 32'(h0));
        check_eq({tag, ".hex1"}, 32'(bus_a.HEX1), 32'(h1));
        check_eq({tag, ".hex2"}, 32'(bus_a.HEX2), 32'(h2));
        check_eq({tag, ".hex3"}, 32'(bus_a.HEX3), 32'(h3));
        check_eq({tag, ".hex4"}, 32'(bus_a.HEX4), 32'(h4));
        check_eq({tag, ".hex5"}, 32'(bus_a.HEX5), 32'(h5));
    endtask

    task automatic check_b(input string tag, input logic [9:0] ledr,
                           input logic [6:0] h0, input logic [6:0] h1);
        check_eq({tag, ".ledr"}, 32'(bus_b.LEDR), 32'(ledr));
        check_eq({tag, ".hex0"}, 32'(bus_b.HEX0), 32'(h0));
        check_eq({tag, ".hex1"}, 32'(bus_b.HEX1), 32'(h1));
        check_eq({tag, ".hex2"}, 32'(bus_b.HEX2), 32'(BL));
        check_eq({tag, ".hex5"}, 32'(bus_b.HEX5), 32'(BL));
    endtask

    // One pushbutton press; outputs are sampled well after the falling edge.
    task automatic press_a(input logic [1:0] mode, input logic [3:0] data);
        bus_a.SW = {mode, 4'b0000, data};
        #2 key_a[0] = 1'b1;
        #5 key_a[0] = 1'b0;
        #3;
    endtask

    task automatic press_b(input logic [1:0] mode, input logic [3:0] data);
        bus_b.SW = {mode, 4'b0000, data};
        #2 key_b[0] = 1'b1;
        #5 key_b[0] = 1'b0;
        #3;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        key_a    = 2'b00;
        key_b    = 2'b00;
        bus_a.SW = '0;
        bus_b.SW = '0;
        #10;
        key_a[1] = 1'b1;
        key_b[1] = 1'b1;
        #5;
        check_a("reset", 10'b0, D, D, D, D, D, D);

        // Shift in 1,2,3
        press_a(2'b01, 4'h1);
        press_a(2'b01, 4'h2);
        press_a(2'b01, 4'h3);
        check_a("shift3", 10'b0000000111, G3, G2, G1, D, D, D);

        // Rotate with a partial fill is a hold
        press_a(2'b10, 4'h0);
        check_a("rot_partial", 10'b0000000111, G3, G2, G1, D, D, D);

        // Async reset mid-sequence, no clock edge
        key_a[1] = 1'b0;
        #1;
        check_a("async_rst", 10'b0, D, D, D, D, D, D);
        #4 key_a[1] = 1'b1;
        #5;

        // Fill with A..F, then overflow with 7
        press_a(2'b01, 4'hA);
        press_a(2'b01, 4'hB);
        press_a(2'b01, 4'hC);
        press_a(2'b01, 4'hD);
        press_a(2'b01, 4'hE);
        press_a(2'b01, 4'hF);
        check_a("full6", 10'b1000111111, GF, GE, GD, GC, GB, GA);
        press_a(2'b01, 4'h7);
        check_a("ovf7", 10'b1100111111, G7, GF, GE, GD, GC, GB);

        // Hold for two edges; data switches wiggle between edges
        press_a(2'b00, 4'h3);
        bus_a.SW = {2'b01, 4'b0000, 4'h9};
        #5;
        check_a("sw_no_edge", 10'b1100111111, G7, GF, GE, GD, GC, GB);
        press_a(2'b00, 4'h5);
        check_a("hold2", 10'b1100111111, G7, GF, GE, GD, GC, GB);

        // Clear after overflow, then one load
        press_a(2'b11, 4'h0);
        check_a("clear", 10'b0, D, D, D, D, D, D);
        press_a(2'b01, 4'h4);
        check_a("after_clear", 10'b0000000001, G4, D, D, D, D, D);

        // Fill with 0..5 then rotate
        press_a(2'b11, 4'h0);
        for (int i = 0; i < 6; i++) begin
            press_a(2'b01, 4'(i));
        end
        check_a("fill05", 10'b1000111111, G5, G4, G3, G2, G1, G0);
        press_a(2'b10, 4'h0);
        check_a("rot1", 10'b1000111111, G0, G5, G4, G3, G2, G1);
        for (int i = 0; i < 5; i++) begin
            press_a(2'b10, 4'h0);
        end
        check_a("rot6", 10'b1000111111, G5, G4, G3, G2, G1, G0);

        // Reset falls at the same instant as a clock rising edge
        bus_a.SW = {2'b01, 4'b0000, 4'h8};
        #2 key_a = 2'b01;
        #3;
        check_a("rst_vs_edge", 10'b0, D, D, D, D, D, D);
        key_a = 2'b00;
        #2 key_a[1] = 1'b1;
        #5;

        // WIDTH=1, DEPTH=2 bank
        check_b("b_reset", 10'b0, D, D);
        press_b(2'b01, 4'hF);
        check_b("b_load1", 10'b0000000001, G1, D);
        press_b(2'b01, 4'hE);
        check_b("b_load2", 10'b1000000011, G0, G1);
        press_b(2'b01, 4'hF);
        check_b("b_ovf", 10'b1100000011, G1, G0);
        press_b(2'b10, 4'h0);
        check_b("b_rot", 10'b1100000011, G0, G1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
